// File: rtl/psec5_regmap_pkg.sv
// rtl/psec5_regmap_pkg.sv - register map, command format and decoder state type
package psec5_regmap_pkg;

    localparam logic [6:0] ADDR_RESERVED  = 7'd0;
    localparam logic [6:0] ADDR_TRIG_MASK = 7'd1;
    localparam logic [6:0] ADDR_INSTR     = 7'd2;
    localparam logic [6:0] ADDR_MODE      = 7'd3;
    localparam int unsigned NUM_REGS      = 59;
    localparam int unsigned WR_FLAG_BIT   = 7;

    typedef enum logic [1:0] {
        S_ADDR  = 2'd0,
        S_WDATA = 2'd1,
        S_RDATA = 2'd2
    } dec_state_e;

    function automatic logic is_writable(input logic [6:0] addr);
        return (addr == ADDR_TRIG_MASK) || (addr == ADDR_INSTR) || (addr == ADDR_MODE);
    endfunction

endpackage

// File: rtl/pico_cmd_decoder_if.sv
// rtl/pico_cmd_decoder_if.sv - host serial input and decoded register outputs
interface pico_cmd_decoder_if;

    logic       serial_in;
    logic [7:0] control_signal;
    logic [7:0] trigger_channel_mask;
    logic [7:0] instruction;
    logic [7:0] mode;
    logic       wr_strobe;
    logic       instr_valid;
    logic       frame_err;

    modport master (
        output serial_in,
        input  control_signal, trigger_channel_mask, instruction, mode,
        input  wr_strobe, instr_valid, frame_err
    );

    modport slave (
        input  serial_in,
        output control_signal, trigger_channel_mask, instruction, mode,
        output wr_strobe, instr_valid, frame_err
    );

endinterface

// File: rtl/s2p_register.sv
// rtl/s2p_register.sv - LSB-first deserialiser with free-running bit counter
module s2p_register (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       serial_in,
    output logic [7:0] byte_data,
    output logic       byte_done
);

    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;

    // Counter never pauses so byte slots stay aligned with the readout serialiser.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 7'd0;
        end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            shift_reg <= {serial_in, shift_reg[6:1]};
        end
    end

    assign byte_data = {serial_in, shift_reg};
    assign byte_done = (bit_cnt == 3'd7);

endmodule

// File: rtl/pico_cmd_decoder.sv
// rtl/pico_cmd_decoder.sv - command FSM and host-writable register file
module pico_cmd_decoder
    import psec5_regmap_pkg::*;
#(
    parameter int unsigned NUM_REGS      = psec5_regmap_pkg::NUM_REGS,
    parameter logic [7:0]  TRIG_MASK_RST = 8'h00,
    parameter logic [7:0]  INSTR_RST     = 8'h00,
    parameter logic [7:0]  MODE_RST      = 8'h00
) (
    input  logic                 sclk,
    input  logic                 rstn,
    pico_cmd_decoder_if.slave    bus
);

    logic [7:0] byte_data;
    logic       byte_done;
    logic [6:0] addr;
    logic       read_ok;
    dec_state_e state;
    logic [6:0] waddr;
    logic       drop;

    s2p_register u_s2p (
        .sclk      (sclk),
        .rstn      (rstn),
        .serial_in (bus.serial_in),
        .byte_data (byte_data),
        .byte_done (byte_done)
    );

    assign addr    = byte_data[6:0];
    assign read_ok = (addr != ADDR_RESERVED) && (32'(addr) <= NUM_REGS);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state                    <= S_ADDR;
            waddr                    <= ADDR_RESERVED;
            drop                     <= 1'b0;
            bus.control_signal       <= 8'h00;
            bus.trigger_channel_mask <= TRIG_MASK_RST;
            bus.instruction          <= INSTR_RST;
            bus.mode                 <= MODE_RST;
            bus.wr_strobe            <= 1'b0;
            bus.instr_valid          <= 1'b0;
            bus.frame_err            <= 1'b0;
        end else begin
            bus.wr_strobe   <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            if (byte_done) begin
                case (state)
                    S_ADDR: begin
                        if (byte_data[WR_FLAG_BIT]) begin
                            // Bad write addresses still consume their data byte.
                            waddr <= addr;
                            drop  <= !is_writable(addr);
                            state <= S_WDATA;
                        end else begin
                            bus.control_signal <= read_ok ? {1'b0, addr} : 8'h00;
                            bus.frame_err      <= !read_ok;
                            state              <= S_RDATA;
                        end
                    end
                    S_WDATA: begin
                        if (drop) begin
                            bus.frame_err <= 1'b1;
                        end else begin
                            bus.wr_strobe <= 1'b1;
                            case (waddr)
                                ADDR_TRIG_MASK: bus.trigger_channel_mask <= byte_data;
                                ADDR_INSTR: begin
                                    bus.instruction <= byte_data;
                                    bus.instr_valid <= 1'b1;
                                end
                                ADDR_MODE:      bus.mode <= byte_data;
                                default:        ;
                            endcase
                        end
                        state <= S_ADDR;
                    end
                    default: state <= S_ADDR;
                endcase
            end
        end
    end

endmodule

// File: doc/pico_cmd_decoder.md
Name: pico_cmd_decoder

Overview:
- Serial command receiver for the configuration port: the host-to-chip (PICO) half of the serial link whose chip-to-host half is the mux/p2s readout path.
- Deserialises sclk-sampled serial_in LSB-first into bytes and decodes address/data frames.
- Holds the three host-writable registers (trigger_channel_mask, instruction, mode).
- Drives control_signal, the readout mux select, so the requested register is shifted out in the byte slot immediately after a read command.

Parameters:
- NUM_REGS, 59, highest valid register address; valid addresses are 1..NUM_REGS.
- TRIG_MASK_RST, 8'h00, reset value of trigger_channel_mask.
- INSTR_RST, 8'h00, reset value of instruction.
- MODE_RST, 8'h00, reset value of mode.

Ports:
- sclk  in  1  serial clock; all state updates on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- serial_in  in  1  host data, LSB first, sampled on posedge sclk.
- control_signal  out  8  readout mux select; reset 0.
- trigger_channel_mask  out  8  address 1 register; reset TRIG_MASK_RST.
- instruction  out  8  address 2 register; reset INSTR_RST.
- mode  out  8  address 3 register; reset MODE_RST.
- wr_strobe  out  1  one-cycle pulse on a committed write; reset 0.
- instr_valid  out  1  one-cycle pulse when instruction is written; reset 0.
- frame_err  out  1  one-cycle pulse on an illegal command; reset 0.

Behaviour:
- Bit counter (3b) is free-running from reset, so byte boundaries align with the readout serialiser. Every sclk edge: shift_reg <= {serial_in, shift_reg[7:1]}.
- A byte completes on the edge where bit_cnt==7. byte = {serial_in, shift_reg[7:1]}. bit_cnt wraps 7->0.
- Command byte format: bit7 = write flag, bits[6:0] = address.
- FSM states: S_ADDR (reset), S_WDATA, S_RDATA. Transitions occur only on byte completion.
- S_ADDR, write flag=1, address in 1..3: latch the address and go to S_WDATA.
- S_ADDR, write flag=1, address otherwise: go to S_WDATA with a drop flag set (the data byte is consumed and discarded).
- S_ADDR, write flag=0, address in 1..NUM_REGS: control_signal <= address on the same edge; go to S_RDATA.
- S_ADDR, write flag=0, address 0 or >NUM_REGS: control_signal <= 0; frame_err pulse; go to S_RDATA.
- S_WDATA: on byte completion, if not dropping, write the byte to the selected register and pulse wr_strobe (and instr_valid if address 2). If dropping, pulse frame_err and change no register. Return to S_ADDR.
- S_RDATA: serial_in is ignored for 8 bits (dummy byte while the readout shifts). Return to S_ADDR.
- control_signal holds its value until the next read command. Writes never change control_signal.
- Latency: a write is visible on the edge that captures data bit 7 (16th edge of the frame). Pulses are registered and high for exactly the cycle following that edge. A read select is updated at the 8th edge, so readout bit 0 is sampled on the 9th edge.
- Back-to-back frames are legal with no idle bits. Mid-byte there are no partial effects.
- Reset mid-operation: all registers and outputs take reset values, FSM goes to S_ADDR, bit_cnt=0. The next 8 bits form an address byte.
- All outputs are registered. No combinational path from serial_in to any output.

Decomposition:
- Package psec5_regmap_pkg holds:
  - ADDR_TRIG_MASK=1, ADDR_INSTR=2, ADDR_MODE=3, ADDR_RESERVED=0, NUM_REGS=59.
  - WR_FLAG_BIT=7.
  - The decoder state enum typedef (S_ADDR/S_WDATA/S_RDATA).
- Sub-module s2p_register holds the shift register and bit counter and outputs byte[7:0] plus byte_done. It is the mirror of the serialiser.
- pico_cmd_decoder holds the FSM and register file.

Test Plan:
- Write instruction:
  - Stimulus: reset, then byte 0x82, then 0xA5, both LSB first.
  - Required: instruction=0xA5 after the 16th edge; wr_strobe and instr_valid each high for exactly 1 cycle; control_signal stays 0; mode and trigger_channel_mask unchanged.
- Read reg5:
  - Stimulus: byte 0x05, then 8 dummy bits of 1.
  - Required: control_signal=5 after the 8th edge; no register changes and no pulses; next byte 0x81,0x3C sets trigger_channel_mask=0x3C while control_signal stays 5.
- Illegal read:
  - Stimulus: byte 0x45 (address 69).
  - Required: control_signal=0 and one frame_err pulse; the following 8 bits are ignored.
- Write to read-only:
  - Stimulus: byte 0x8A, then 0xFF.
  - Required: all writable registers unchanged, wr_strobe never asserted, one frame_err pulse after the 16th edge; the next byte is decoded as an address.
- Reset mid-frame:
  - Stimulus: write 0x83,0x7E to set mode=0x7E; send 4 bits of a new byte; drop rstn asynchronously between edges.
  - Required: mode=MODE_RST and all outputs at reset values immediately; after release, byte 0x83,0x11 sets mode=0x11.
- Back-to-back:
  - Stimulus: 0x81,0x0F,0x83,0x02 with no gap.
  - Required: trigger_channel_mask=0x0F at edge 16, mode=0x02 at edge 32; wr_strobe pulses twice.
